// File: rtl/bsg_cover_drain_ctrl.sv
// Drain controller for the coverage realign chains.
// Tracks each sample's realign latency, captures the vector once aligned and
// streams it out as out_width_p-bit words. Single-entry buffer: a sample that
// aligns while the buffer is still draining is dropped and counted.
module bsg_cover_drain_ctrl #(
  parameter int num_p       = 64,
  parameter int max_depth_p = 4,
  parameter int out_width_p = 32,
  parameter int cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   v_i,
  input  logic [num_p-1:0]       data_i,
  input  logic                   clr_drop_i,
  output logic                   v_o,
  output logic [out_width_p-1:0] data_o,
  output logic                   last_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic [cnt_width_p-1:0] drop_cnt_o
);

  localparam int words_lp     = (num_p + out_width_p - 1) / out_width_p;
  localparam int idx_width_lp = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int buf_width_lp = words_lp * out_width_p;
  localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(words_lp - 1);

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  logic [max_depth_p-1:0]  pipe_q, pipe_d;
  state_e                  state_q, state_d;
  logic [idx_width_lp-1:0] idx_q, idx_d;
  logic [buf_width_lp-1:0] buf_q, buf_d;
  logic [out_width_p-1:0]  data_q, data_d;
  logic                    last_q, last_d;
  logic [cnt_width_p-1:0]  drop_cnt_q, drop_cnt_d;

  logic                    aligned;
  logic                    hs;
  logic                    last_word;
  logic                    drop;
  logic [buf_width_lp-1:0] padded;

  assign aligned   = pipe_q[max_depth_p-1];
  assign hs        = (state_q == SEND) & ready_i;
  assign last_word = (idx_q == last_idx_lp);

  // Valid-bit shift register mirroring the realign latency.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = v_i & en_i;
    for (int unsigned i = 1; i < max_depth_p; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Capture/serialize FSM next state, including back-to-back capture on last handshake.
  always_comb begin
    padded               = '0;
    padded[num_p-1:0]    = data_i;
    state_d              = state_q;
    idx_d                = idx_q;
    buf_d                = buf_q;
    drop                 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aligned) begin
          buf_d   = padded;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hs && last_word) begin
          idx_d = '0;
          if (aligned) begin
            buf_d = padded;
          end else begin
            state_d = IDLE;
          end
        end else begin
          if (hs) begin
            idx_d = idx_q + 1'b1;
          end
          if (aligned) begin
            drop = 1'b1;
          end
        end
      end
    endcase
  end

  // Registered output word selection from the next buffer/index.
  always_comb begin
    data_d = '0;
    for (int unsigned w = 0; w < words_lp; w++) begin
      if (idx_d == idx_width_lp'(w)) begin
        data_d = buf_d[w*out_width_p +: out_width_p];
      end
    end
    last_d = (state_d == SEND) && (idx_d == last_idx_lp);
  end

  // Saturating drop counter; clear wins over a same-cycle drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clr_drop_i) begin
      drop_cnt_d = '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_q     <= '0;
      state_q    <= IDLE;
      idx_q      <= '0;
      buf_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      data_q     <= data_d;
      last_q     <= last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign v_o        = (state_q == SEND);
  assign data_o     = data_q;
  assign last_o     = last_q;
  assign busy_o     = (|pipe_q) | (state_q == SEND);
  assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bsg_cover_drain_ctrl.sv
// Testbench for bsg_cover_drain_ctrl: per-cycle vector table plus a word scoreboard.
module tb_bsg_cover_drain_ctrl;

  localparam logic [63:0] J = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] D = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] E = 64'hFEDC_BA98_7654_3210;
  localparam logic [31:0] H = 32'h89AB_CDEF;
  localparam logic [31:0] L = 32'h0123_4567;

  logic        clk = 1'b0;
  logic        rst, en, v, rdy, clr;
  logic [63:0] data;

  logic        d0_v, d0_last, d0_busy;
  logic [31:0] d0_data;
  logic [15:0] d0_drop;
  logic        d1_v, d1_last, d1_busy;
  logic [31:0] d1_data;
  logic [1:0]  d1_drop;
  logic        d2_v, d2_last, d2_busy;
  logic [63:0] d2_data;
  logic [15:0] d2_drop;

  int checks = 0;
  int errors = 0;
  int cur    = 0;

  typedef struct {
    logic        rst, v, en, rdy, clr, push;
    logic [63:0] data;
    int          mode;
    logic        ev, eb;
    logic [15:0] ed;
    logic [31:0] edat;
    logic        el;
  } vec_t;

  vec_t        vecs[$];
  logic [32:0] sb[$];
  logic [32:0] exp_w;

  always #5 clk = ~clk;

  bsg_cover_drain_ctrl #(.num_p(64), .max_depth_p(4), .out_width_p(32), .cnt_width_p(16)) dut0 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .data_i(data), .clr_drop_i(clr),
    .v_o(d0_v), .data_o(d0_data), .last_o(d0_last), .ready_i(rdy), .busy_o(d0_busy),
    .drop_cnt_o(d0_drop));

  bsg_cover_drain_ctrl #(.num_p(40), .max_depth_p(4), .out_width_p(32), .cnt_width_p(2)) dut1 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .data_i(data[39:0]), .clr_drop_i(clr),
    .v_o(d1_v), .data_o(d1_data), .last_o(d1_last), .ready_i(rdy), .busy_o(d1_busy),
    .drop_cnt_o(d1_drop));

  bsg_cover_drain_ctrl #(.num_p(64), .max_depth_p(4), .out_width_p(64), .cnt_width_p(16)) dut2 (
    .clk_i(clk), .reset_i(rst), .en_i(en), .v_i(v), .data_i(data), .clr_drop_i(clr),
    .v_o(d2_v), .data_o(d2_data), .last_o(d2_last), .ready_i(rdy), .busy_o(d2_busy),
    .drop_cnt_o(d2_drop));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic vv, input logic e, input logic rd, input logic c,
                     input logic p, input logic [63:0] dt, input int m, input logic ev,
                     input logic eb, input logic [15:0] ed, input logic [31:0] edat,
                     input logic el);
    vec_t x;
    x.rst = r; x.v = vv; x.en = e; x.rdy = rd; x.clr = c; x.push = p; x.data = dt;
    x.mode = m; x.ev = ev; x.eb = eb; x.ed = ed; x.edat = edat; x.el = el;
    vecs.push_back(x);
  endtask

  task automatic rs();
    add(1, 0, 1, 0, 0, 0, J, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, J, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted word of dut0 must match the next expected word.
  always @(negedge clk) begin
    if (!rst && d0_v && rdy) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected word got %h last %b want none", d0_data, d0_last);
      end else begin
        exp_w = sb.pop_front();
        checks++;
        if ({d0_data, d0_last} !== exp_w) begin
          errors++;
          $display("FAIL sb_word got %h/%b want %h/%b", d0_data, d0_last, exp_w[32:1], exp_w[0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b1; v = 1'b0; rdy = 1'b0; clr = 1'b0; data = J;

    // reset values, then reset asserted mid-SEND with a drop pending and samples in flight
    add(0, 1, 1, 0, 0, 0, J, 2, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, D, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 1, 1, 0, 0, 0, J, 1, 1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, J, 1, 1, 1, 1, 0, 0);
    add(1, 0, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 2, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // latency and word order
    rs();
    add(0, 1, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 1, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, D, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, L, 1);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // backpressure
    rs();
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, D, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, L, 1);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // back-to-back samples, no bubble, no drop
    rs();
    add(0, 1, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 1, D, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 1, 0, 1, E, 2, 1, 1, 0, L, 1);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, 32'h7654_3210, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, 32'hFEDC_BA98, 1);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // drops while draining, then clear
    rs();
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, D, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, E, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 0, 0, 0, E, 1, 1, 1, 1, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 1, 1, 2, 0, 0);
    for (int i = 0; i < 12; i++) add(0, 0, 1, 0, 0, 0, J, 2, 1, 1, 2, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 2, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 2, L, 1);
    add(0, 0, 1, 1, 1, 0, J, 1, 0, 0, 2, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // clear beats a same-cycle drop
    rs();
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 1, D, 1, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, E, 1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, J, 1, 1, 1, 0, 0, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 1, 1, 0, 0, J, 2, 1, 1, 0, L, 1);
    add(0, 0, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    // enable gates new samples only; in-flight samples survive en_i low
    rs();
    for (int i = 0; i < 3; i++) add(0, 1, 0, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, 0, J, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, D, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, J, 2, 1, 1, 0, H, 0);
    add(0, 0, 0, 1, 0, 0, J, 2, 1, 1, 0, L, 1);
    add(0, 0, 0, 1, 0, 0, J, 1, 0, 0, 0, 0, 0);

    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cur  = i;
      rst  = vecs[i].rst;
      v    = vecs[i].v;
      en   = vecs[i].en;
      rdy  = vecs[i].rdy;
      clr  = vecs[i].clr;
      data = vecs[i].data;
      if (vecs[i].mode >= 1) begin
        chk("v_o", {63'd0, d0_v}, {63'd0, vecs[i].ev});
        chk("busy_o", {63'd0, d0_busy}, {63'd0, vecs[i].eb});
        chk("drop_cnt_o", {48'd0, d0_drop}, {48'd0, vecs[i].ed});
      end
      if (vecs[i].mode == 2) begin
        chk("data_o", {32'd0, d0_data}, {32'd0, vecs[i].edat});
        chk("last_o", {63'd0, d0_last}, {63'd0, vecs[i].el});
      end
      if (vecs[i].rst) sb.delete();
      if (vecs[i].push) begin
        sb.push_back({vecs[i].data[31:0], 1'b0});
        sb.push_back({vecs[i].data[63:32], 1'b1});
      end
      tick();
    end

    // zero-padded last word (num_p=40) and single-word output (out_width_p=64)
    cur = 1000;
    rst = 1'b1; v = 1'b0; en = 1'b1; rdy = 1'b1; clr = 1'b0; data = J;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      cur  = 1000 + c;
      v    = (c == 0);
      data = (c == 4) ? D : J;
      if (c == 4) begin
        sb.push_back({D[31:0], 1'b0});
        sb.push_back({D[63:32], 1'b1});
      end
      if (c == 5) begin
        chk("pad_v", {63'd0, d1_v}, 64'd1);
        chk("pad_w0", {32'd0, d1_data}, {32'd0, H});
        chk("pad_last0", {63'd0, d1_last}, 64'd0);
        chk("w1_v", {63'd0, d2_v}, 64'd1);
        chk("w1_data", d2_data, D);
        chk("w1_last", {63'd0, d2_last}, 64'd1);
      end
      if (c == 6) begin
        chk("pad_w1", {32'd0, d1_data}, 64'h0000_0000_0000_0067);
        chk("pad_last1", {63'd0, d1_last}, 64'd1);
        chk("w1_v_after", {63'd0, d2_v}, 64'd0);
      end
      if (c == 7) chk("pad_v_after", {63'd0, d1_v}, 64'd0);
      tick();
    end

    // drop counter saturation (cnt_width_p=2, five drops)
    cur = 2000;
    rst = 1'b1; v = 1'b0; rdy = 1'b0; data = J;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c <= 10; c++) begin
      cur  = 2000 + c;
      v    = (c <= 5);
      data = (c == 4) ? D : J;
      if (c >= 6) chk("sat_drop", {62'd0, d1_drop}, ((c - 5) > 3) ? 64'd3 : 64'(c - 5));
      if (c == 10) chk("wide_drop", {48'd0, d0_drop}, 64'd5);
      tick();
    end
    rst = 1'b1; v = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
